// File: rtl/tile_sequencer.sv
// Tile block-memory sequencer: after one start command, drives diagonally skewed per-lane A/D/B
// read addresses and the matching C write-back addresses a fixed latency later.
module tile_sequencer #(
    parameter int unsigned BITWIDTH  = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 4,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [BITWIDTH-1:0]                  rows,
    input  logic [BITWIDTH-1:0]                  A_base,
    input  logic [BITWIDTH-1:0]                  D_base,
    input  logic [BITWIDTH-1:0]                  B_base,
    input  logic [BITWIDTH-1:0]                  C_base,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]   A_tile_read_addrs,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]   D_tile_read_addrs,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]   B_tile_read_addrs,
    output logic [MESHUNITS-1:0]                 A_read_valid,
    output logic [MESHUNITS-1:0]                 D_read_valid,
    output logic [MESHUNITS-1:0]                 B_read_valid,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]   C_tile_write_addrs,
    output logic [MESHUNITS-1:0]                 C_write_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned TW = BITWIDTH + 1;
    localparam int unsigned CW = BITWIDTH + 2;
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
    localparam logic [BITWIDTH-1:0] WrBack = BITWIDTH'(LATENCY * TILEUNITS);
    localparam logic [TW-1:0] EndExtra = TW'(MESHUNITS - 1 + LATENCY - 1);

    logic [1:0]                          r_state;
    logic [TW-1:0]                       r_t;
    logic [TW-1:0]                       r_end;
    logic [BITWIDTH-1:0]                 r_k;
    logic [BITWIDTH-1:0]                 r_a_base, r_d_base, r_b_base, r_c_base;
    // r_off[i] tracks (i*K + t - i) * TILEUNITS; the write offset is the same minus LATENCY steps
    logic [MESHUNITS-1:0][BITWIDTH-1:0]  r_off;

    logic [BITWIDTH-1:0]                 w_lane_stride;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]  w_init_off;
    logic [MESHUNITS-1:0]                w_rd_valid;
    logic [MESHUNITS-1:0]                w_wr_valid;
    logic [CW-1:0]                       w_t_ext;
    logic                                w_run;

    assign w_lane_stride = (rows - BITWIDTH'(1)) * BITWIDTH'(TILEUNITS);

    for (genvar g = 0; g < MESHUNITS; g++) begin : g_init
        assign w_init_off[g] = BITWIDTH'(g) * w_lane_stride;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_t      <= '0;
            r_end    <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_d_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            r_off    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        if (rows != '0) begin
                            r_k      <= rows;
                            r_end    <= TW'(rows) + EndExtra;
                            r_a_base <= A_base;
                            r_d_base <= D_base;
                            r_b_base <= B_base;
                            r_c_base <= C_base;
                            r_t      <= '0;
                            r_off    <= w_init_off;
                            r_state  <= StRun;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        r_state <= StIdle;
                    end else if (r_t == r_end) begin
                        r_state <= StDone;
                    end else begin
                        r_t <= r_t + TW'(1);
                        for (int unsigned i = 0; i < MESHUNITS; i++) begin
                            r_off[i] <= r_off[i] + BITWIDTH'(TILEUNITS);
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_run   = (r_state == StRun);
    assign w_t_ext = CW'(r_t);
    assign busy    = w_run;
    assign done    = (r_state == StDone);

    always_comb begin
        w_rd_valid         = '0;
        w_wr_valid         = '0;
        A_tile_read_addrs  = '0;
        D_tile_read_addrs  = '0;
        B_tile_read_addrs  = '0;
        C_tile_write_addrs = '0;
        for (int unsigned i = 0; i < MESHUNITS; i++) begin
            w_rd_valid[i] = w_run && (w_t_ext >= CW'(i))
                            && (w_t_ext < CW'(r_k) + CW'(i));
            w_wr_valid[i] = w_run && (w_t_ext >= CW'(i + LATENCY))
                            && (w_t_ext < CW'(r_k) + CW'(i + LATENCY));
            if (w_rd_valid[i]) begin
                A_tile_read_addrs[i] = r_a_base + r_off[i];
                D_tile_read_addrs[i] = r_d_base + r_off[i];
                B_tile_read_addrs[i] = r_b_base + r_off[i];
            end
            if (w_wr_valid[i]) begin
                C_tile_write_addrs[i] = r_c_base + r_off[i] - WrBack;
            end
        end
    end

    assign A_read_valid  = w_rd_valid;
    assign D_read_valid  = w_rd_valid;
    assign B_read_valid  = w_rd_valid;
    assign C_write_valid = w_wr_valid;

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: directed scenarios plus random traffic, every cycle checked against
// an address-formula reference model.
module tb_tile_sequencer;

    localparam int unsigned BW  = 8;
    localparam int unsigned MU  = 2;
    localparam int unsigned TU  = 2;
    localparam int unsigned LAT = 3;
    localparam int MASK = (1 << BW) - 1;
    // K=1 back-to-back period: RUN (END+1 cycles) + DONE + IDLE
    localparam int PERIOD1 = (1 + MU - 1 + LAT - 1) + 1 + 2;

    logic clock = 1'b0;
    logic reset, start, abort;
    logic [BW-1:0] rows, a_base, d_base, b_base, c_base;
    logic [MU-1:0][BW-1:0] a_addr, d_addr, b_addr, c_addr;
    logic [MU-1:0] a_v, d_v, b_v, c_v;
    logic busy, done;

    int checks = 0;
    int errors = 0;

    int m_state = 0;  // 0 idle, 1 run, 2 done
    int m_t = 0, m_k = 0, m_end = 0;
    int m_a = 0, m_d = 0, m_b = 0, m_c = 0;

    tile_sequencer #(
        .BITWIDTH (BW),
        .MESHUNITS(MU),
        .TILEUNITS(TU),
        .LATENCY  (LAT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .rows              (rows),
        .A_base            (a_base),
        .D_base            (d_base),
        .B_base            (b_base),
        .C_base            (c_base),
        .A_tile_read_addrs (a_addr),
        .D_tile_read_addrs (d_addr),
        .B_tile_read_addrs (b_addr),
        .A_read_valid      (a_v),
        .D_read_valid      (d_v),
        .B_read_valid      (b_v),
        .C_tile_write_addrs(c_addr),
        .C_write_valid     (c_v),
        .busy              (busy),
        .done              (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state advance, using the inputs sampled at this edge
    task automatic model_edge();
        if (reset) begin
            m_state = 0;
            m_t     = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    if (rows == 0) begin
                        m_state = 2;
                    end else begin
                        m_k   = int'(rows);
                        m_end = m_k + MU - 1 + LAT - 1;
                        m_a   = int'(a_base);
                        m_d   = int'(d_base);
                        m_b   = int'(b_base);
                        m_c   = int'(c_base);
                        m_t   = 0;
                        m_state = 1;
                    end
                end
                1: if (abort) m_state = 0;
                   else if (m_t == m_end) m_state = 2;
                   else m_t++;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("busy", busy, (m_state == 1) ? 1 : 0);
        chk("done", done, (m_state == 2) ? 1 : 0);
        for (int i = 0; i < MU; i++) begin
            int r, w, rv, wv;
            r  = m_t - i;
            w  = m_t - i - LAT;
            rv = (m_state == 1 && r >= 0 && r < m_k) ? 1 : 0;
            wv = (m_state == 1 && w >= 0 && w < m_k) ? 1 : 0;
            chk($sformatf("a_valid[%0d]", i), a_v[i], rv);
            chk($sformatf("d_valid[%0d]", i), d_v[i], rv);
            chk($sformatf("b_valid[%0d]", i), b_v[i], rv);
            chk($sformatf("c_valid[%0d]", i), c_v[i], wv);
            chk($sformatf("a_addr[%0d]", i), a_addr[i], rv ? ((m_a + (i * m_k + r) * TU) & MASK) : 0);
            chk($sformatf("d_addr[%0d]", i), d_addr[i], rv ? ((m_d + (i * m_k + r) * TU) & MASK) : 0);
            chk($sformatf("b_addr[%0d]", i), b_addr[i], rv ? ((m_b + (i * m_k + r) * TU) & MASK) : 0);
            chk($sformatf("c_addr[%0d]", i), c_addr[i], wv ? ((m_c + (i * m_k + w) * TU) & MASK) : 0);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int done_at, busy_n, done_n, rd1_n, wr1_n;
        int q0[$];
        int q1[$];

        reset = 1'b1; start = 1'b0; abort = 1'b0; rows = '0;
        a_base = '0; d_base = '0; b_base = '0; c_base = '0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Basic run
        rows = 8'd3; a_base = 8'h10; d_base = 8'h20; b_base = 8'h30; c_base = 8'h40;
        start = 1'b1;
        done_at = 0; busy_n = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            start = 1'b0;
            if (busy) busy_n++;
            if (a_v[0]) q0.push_back(int'(a_addr[0]));
            if (c_v[1]) q1.push_back(int'(c_addr[1]));
            if (done && done_at == 0) done_at = k;
        end
        chk("s1_done_cycle", done_at, 8);
        chk("s1_busy_cycles", busy_n, 7);
        chk("s1_lane0_reads", q0.size(), 3);
        chk("s1_lane0_third", q0[2], 'h14);
        chk("s1_c1_writes", q1.size(), 3);
        chk("s1_c1_first", q1[0], 'h46);
        chk("s1_c1_last", q1[2], 'h4A);

        // Zero rows
        rows = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("s2_done", done, 1);
        chk("s2_busy", busy, 0);
        cyc();
        cyc();

        // Abort at t=2, then restart
        rows = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("s3_valids_off", {a_v, c_v}, 0);
        cyc();
        chk("s3_no_done", done, 0);
        start = 1'b1;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            start = 1'b0;
            if (done) done_n++;
        end
        chk("s3_restart_done", done_n, 1);

        // Reset mid-run with start held
        rows = 8'd3; start = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        start = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s4_busy", busy, 0);
        chk("s4_valids", {a_v, c_v}, 0);
        busy_n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (busy) busy_n++;
        end
        chk("s4_no_rerun", busy_n, 0);

        // Wrap-around
        rows = 8'd3; a_base = 8'hFC; start = 1'b1;
        q0.delete(); q1.delete();
        for (int k = 0; k < 12; k++) begin
            cyc();
            start = 1'b0;
            if (a_v[0]) q0.push_back(int'(a_addr[0]));
            if (a_v[1]) q1.push_back(int'(a_addr[1]));
        end
        chk("s5_lane0_wrap", q0[2], 'h00);
        chk("s5_lane1_first", q1[0], 'h02);
        chk("s5_lane1_last", q1[2], 'h06);

        // Back-to-back with start held
        rows = 8'd1; start = 1'b1;
        done_n = 0; rd1_n = 0; wr1_n = 0;
        for (int k = 0; k < 3 * PERIOD1; k++) begin
            cyc();
            if (done) done_n++;
            if (a_v[1]) rd1_n++;
            if (c_v[1]) wr1_n++;
        end
        start = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk("s6_done_pulses", done_n, 3);
        chk("s6_lane1_reads", rd1_n, 3);
        chk("s6_lane1_writes", wr1_n, 3);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            reset  = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 39) == 0);
            rows   = ($urandom_range(0, 9) == 0) ? BW'($urandom_range(250, 255))
                                                 : BW'($urandom_range(0, 5));
            a_base = BW'($urandom);
            d_base = BW'($urandom);
            b_base = BW'($urandom);
            c_base = BW'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
